md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the E stage. Owns the HI/LO register pair.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E. Produces Start/Busy for the hazard
//  unit, which stalls D-stage mul/div instructions while (Start|Busy).
//  Commits results to HI/LO after a fixed latency per operation class.
// PARAMETERS
//  MULT_CYCLES  5   Busy cycles for MULT/MULTU (legal range 1..15)
//  DIV_CYCLES   10  Busy cycles for DIV/DIVU (legal range 1..15)
// PORTS
//  clk     in   1   clock; all state changes on rising edge
//  reset   in   1   asynchronous, active-low reset
//  md_op   in   3   E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//  A       in   32  forwarded rs value (E stage)
//  B       in   32  forwarded rt value (E stage)
//  kill    in   1   E-stage instruction flushed (exception/interrupt); blocks launch/write
//  Start   out  1   combinational: md_op in {1..4} & !kill & !Busy
//  Busy    out  1   registered: operation in flight
//  HI      out  32  HI register (registered)
//  LO      out  32  LO register (registered)
// BEHAVIOUR
//  Reset (reset==0, asynchronous): Busy=0, HI=0, LO=0, counter=0, shadow results=0.
//  States: IDLE (Busy=0), RUN (Busy=1). 4-bit down-counter cnt.
//  IDLE:
//   - Start=1 at edge T: capture result into shadow hi_s/lo_s. Load cnt with
//     MULT_CYCLES or DIV_CYCLES. Go to RUN.
//   - MTHI & !kill: HI<=A. MTLO & !kill: LO<=A. No Busy.
//  RUN:
//   - Busy=1 for exactly N cycles (T+1..T+N).
//   - Each edge decrements cnt. At the edge where cnt==1: HI<=hi_s, LO<=lo_s, go to IDLE.
//   - New HI/LO values are visible in the first cycle with Busy=0.
//   - Ops presented while Busy are ignored (Start is forced 0). The hazard unit
//     guarantees none arrive; the bench checks this with an assertion.
//   - kill during RUN has no effect. The in-flight op belongs to an older instruction
//     that has already left E, so it still commits.
//  Arithmetic:
//   - MULT: signed 32x32 -> 64; {HI,LO} = product.
//   - MULTU: same, unsigned.
//   - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign
//     of the dividend. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//   - DIVU: unsigned quotient/remainder.
//   - Divide by zero (B==0): the op still runs the full DIV_CYCLES with Busy.
//     HI/LO are left unchanged at commit.
//  Simultaneous events:
//   - md_op and kill together in IDLE: nothing launches or writes.
//   - reset mid-RUN: pending result is discarded and Busy drops immediately.
//  Illegal md_op value (7): treated as NONE.
// STRUCTURE
//  Shared header md_defs.vh:
//   - MD_NONE..MD_MTLO op encodings (also used by the controller decode)
//   - default MULT_CYCLES / DIV_CYCLES
//  Sub-module md_alu (combinational): md_op, A, B -> {hi_r, lo_r, dz}. Holds the signed
//  and unsigned multiply/divide and the divide-by-zero flag. md_sequencer keeps only the
//  FSM, counter, shadow registers and HI/LO.
// TESTING
//  1. Reset low mid-RUN of a DIV.
//     -> Busy=0 and HI=LO=0 immediately. After release, Busy stays 0 with md_op=NONE.
//  2. MULT A=0xFFFFFFFE, B=3.
//     -> Start=1 in cycle T; Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//     MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//  3. Signed divide cases:
//     DIV A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4. Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIVU B=0.
//     -> Busy 10 cycles; HI=0x1234, LO=0x5678 unchanged afterwards.
//  5. MULT with kill=1 in its E cycle -> Start=0, Busy stays 0, HI/LO unchanged.
//     Then DIV launched, with kill=1 asserted during RUN -> DIV still commits.
//  6. MTHI presented while Busy=1 -> HI unchanged and the assertion fires.
//     Back-to-back MULT presented the cycle Busy falls -> launches; new Busy window
//     starts the next cycle.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings
// (also used by the controller decode), default latencies, FSM states.
package md_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the sequencer for a multi-cycle window.
  function automatic logic is_launch(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_alu.sv
// Combinational multiply/divide datapath. Result is captured into the
// sequencer's shadow registers at launch and committed after the latency.
module md_alu
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_r,
  output logic [31:0] lo_r,
  output logic        dz
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Products and sign-magnitude division; the quotient is negated when operand
  // signs differ, the remainder follows the dividend. Working in magnitudes
  // makes 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    sgn    = (md_op == MD_DIV);
    a_neg  = sgn & a[31];
    b_neg  = sgn & b[31];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    dz     = is_div(md_op) && (b == 32'd0);
    // Keep the divider defined on B==0; the result is discarded at commit.
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    hi_r   = 32'd0;
    lo_r   = 32'd0;
    case (md_op)
      MD_MULT:  {hi_r, lo_r} = prod_s;
      MD_MULTU: {hi_r, lo_r} = prod_u;
      MD_DIV, MD_DIVU: begin
        lo_r = (a_neg ^ b_neg) ? -q_mag : q_mag;
        hi_r = a_neg ? -r_mag : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer. Owns HI/LO, runs MULT/DIV for a fixed
// busy window and commits shadowed results when the window closes.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        kill,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] hi_s;
  logic [31:0] lo_s;
  logic        dz_s;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        dz;

  md_alu u_alu (
    .md_op (md_op),
    .a     (A),
    .b     (B),
    .hi_r  (hi_r),
    .lo_r  (lo_r),
    .dz    (dz)
  );

  assign Busy = (state == S_RUN);

  // Launch request for the hazard unit; suppressed for killed ops and while busy.
  always_comb begin
    Start = is_launch(md_op) && !kill && (state == S_IDLE);
  end

  // Sequencer FSM: shadow capture at launch, down-count, commit on the last busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      hi_s  <= 32'd0;
      lo_s  <= 32'd0;
      dz_s  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            hi_s  <= hi_r;
            lo_s  <= lo_r;
            dz_s  <= dz;
            cnt   <= is_div(md_op) ? DIV_N : MULT_N;
            state <= S_RUN;
          end else if (!kill && md_op == MD_MTHI) begin
            HI <= A;
          end else if (!kill && md_op == MD_MTLO) begin
            LO <= A;
          end
        end
        S_RUN: begin
          // kill is ignored here: the in-flight op belongs to an older instruction.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!dz_s) begin
              HI <= hi_s;
              LO <= lo_s;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: the driver predicts commits from a
// 64-bit arithmetic model and queues them; a monitor checks each commit when
// Busy falls.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        kill = 1'b0;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .kill  (kill),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] pend = 64'd0;
  int          exp_busy_ops = 0;
  int          seen_busy_ops = 0;
  int          blen = 0;
  logic        bprev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {HI,LO} after commit.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint q;
    longint r;
    case (op)
      3'd1: return 64'(sa * sbv);
      3'd2: return 64'(ua * ub);
      3'd3: begin
        if (b == 0) return cur;
        q = sa / sbv; r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return cur;
        q = ua / ub; r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      default: return cur;
    endcase
  endfunction

  // One cycle of stimulus; checks Start/Busy and advances the model.
  task automatic cyc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic k);
    logic st;
    int   n;
    md_op = op; A = a; B = b; kill = k;
    @(negedge clk);
    st = (op >= 3'd1 && op <= 3'd4) && !k && (m_left == 0);
    chk("start", 64'(Start), 64'(st));
    chk("busy", 64'(Busy), 64'(m_left > 0));
    if (m_left > 0 && op >= 3'd1 && op <= 3'd6) exp_busy_ops++;
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = pend[63:32]; m_lo = pend[31:0]; end
    end else if (st) begin
      pend = ref_op(op, a, b, {m_hi, m_lo});
      n = (op >= 3'd3) ? 10 : 5;
      m_left = n;
      sb.push_back('{pend[63:32], pend[31:0], n});
    end else if (!k && op == 3'd5) begin
      m_hi = a;
    end else if (!k && op == 3'd6) begin
      m_lo = a;
    end
    #1;
  endtask

  task automatic run_idle(input logic k);
    while (m_left > 0) cyc(3'd0, 32'd0, 32'd0, k);
    cyc(3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Monitor: measure each busy window and check the commit when it closes;
  // also flags any op presented while busy.
  always @(negedge clk) begin
    if (!reset) begin
      blen = 0;
      bprev = 1'b0;
    end else begin
      if (Busy && md_op >= 3'd1 && md_op <= 3'd6) seen_busy_ops++;
      if (Busy) blen++;
      else if (bprev) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL commit_unexpected: got busy window %0d want none", blen);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_hi", 64'(HI), 64'(e.hi));
          chk("commit_lo", 64'(LO), 64'(e.lo));
          chk("busy_len", 64'(blen), 64'(e.len));
        end
        blen = 0;
      end
      bprev = Busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rk;
    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // 1. Reset mid-RUN of a DIV
    cyc(3'd5, 32'hAAAA5555, 32'd0, 1'b0);
    cyc(3'd6, 32'h5555AAAA, 32'd0, 1'b0);
    cyc(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (4) cyc(3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #2;
    chk("midrun_busy", 64'(Busy), 64'd0);
    chk("midrun_hi", 64'(HI), 64'd0);
    chk("midrun_lo", 64'(LO), 64'd0);
    sb.delete(); m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) cyc(3'd0, 32'd0, 32'd0, 1'b0);

    // 2. MULT / MULTU
    cyc(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    run_idle(1'b0);
    chk("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    cyc(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    run_idle(1'b0);
    chk("multu_hilo", {HI, LO}, 64'h00000002_FFFFFFFA);

    // 3. Signed divide
    cyc(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_idle(1'b0);
    chk("div_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    cyc(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_idle(1'b0);
    chk("div_ovf", {HI, LO}, 64'h00000000_80000000);

    // 4. Divide by zero leaves HI/LO alone
    cyc(3'd5, 32'h1234, 32'd0, 1'b0);
    cyc(3'd6, 32'h5678, 32'd0, 1'b0);
    cyc(3'd4, 32'd99, 32'd0, 1'b0);
    run_idle(1'b0);
    chk("dz_hilo", {HI, LO}, 64'h00001234_00005678);

    // 5. Killed MULT, then DIV with kill during RUN
    cyc(3'd1, 32'd7, 32'd9, 1'b1);
    cyc(3'd0, 32'd0, 32'd0, 1'b0);
    chk("kill_hilo", {HI, LO}, 64'h00001234_00005678);
    cyc(3'd5, 32'hBAD, 32'd0, 1'b1);
    cyc(3'd3, 32'd100, 32'd7, 1'b0);
    run_idle(1'b1);
    chk("div_killrun", {HI, LO}, 64'h00000002_0000000E);

    // 6. MTHI while busy is ignored; back-to-back MULT as Busy falls
    cyc(3'd4, 32'd50, 32'd8, 1'b0);
    cyc(3'd5, 32'hDEAD, 32'd0, 1'b0);
    while (m_left > 0) cyc(3'd0, 32'd0, 32'd0, 1'b0);
    chk("busy_mthi_hi", 64'(HI), 64'd2);
    cyc(3'd1, 32'd6, 32'd7, 1'b0);
    run_idle(1'b0);
    chk("b2b_hilo", {HI, LO}, 64'h00000000_0000002A);

    // Randomized traffic respecting the hazard contract
    for (int i = 0; i < 400; i++) begin
      rk = ($urandom % 6) == 0;
      ra = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
      case ($urandom % 4)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      op = (m_left > 0) ? 3'd0 : 3'($urandom_range(0, 7));
      cyc(op, ra, rb, rk);
    end
    run_idle(1'b0);
    repeat (2) cyc(3'd0, 32'd0, 32'd0, 1'b0);

    chk("final_hilo", {HI, LO}, {m_hi, m_lo});
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("busy_op_events", 64'(seen_busy_ops), 64'(exp_busy_ops));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
